// File: rtl/hist_cdf_lut_gen_if.sv
// Sweep-engine bus: start/status handshake, histogram RAM port and LUT write port.
interface hist_cdf_lut_gen_if #(
  parameter int unsigned C_ADDR_WIDTH = 8,
  parameter int unsigned C_DATA_WIDTH = 20,
  parameter int unsigned C_OUT_WIDTH  = 8
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    hist_wren;
  logic [C_ADDR_WIDTH-1:0] hist_addr;
  logic [C_DATA_WIDTH-1:0] hist_din;
  logic [C_DATA_WIDTH-1:0] hist_dout;
  logic                    lut_wren;
  logic [C_ADDR_WIDTH-1:0] lut_addr;
  logic [C_OUT_WIDTH-1:0]  lut_din;

  modport master (
    input  start, hist_dout,
    output busy, done, hist_wren, hist_addr, hist_din, lut_wren, lut_addr, lut_din
  );

  modport slave (
    output start, hist_dout,
    input  busy, done, hist_wren, hist_addr, hist_din, lut_wren, lut_addr, lut_din
  );
endinterface

// File: rtl/hist_cdf_lut_gen.sv
// Post-frame sweep: reads each histogram bin, accumulates the CDF, writes the scaled
// equalization LUT and clears the bin behind the read.
module hist_cdf_lut_gen #(
  parameter int unsigned C_ADDR_WIDTH = 8,
  parameter int unsigned C_DATA_WIDTH = 20,
  parameter int unsigned C_PIX_NUM    = 307200,
  parameter int unsigned C_OUT_WIDTH  = 8
) (
  input logic                clk,
  input logic                rst_n,
  hist_cdf_lut_gen_if.master bus
);

  localparam int unsigned M  = (2 ** C_OUT_WIDTH) - 1;
  localparam int unsigned PW = C_DATA_WIDTH + C_OUT_WIDTH + 25;
  // K = ceil(M * 2^24 / C_PIX_NUM): fixed-point reciprocal of the pixel count.
  localparam logic [63:0] KVal =
      ((64'(M) << 24) + 64'(C_PIX_NUM) - 64'd1) / 64'(C_PIX_NUM);
  localparam logic [PW-1:0] K = PW'(KVal);

  typedef enum logic [1:0] {StIdle, StRead, StClear, StDone} state_e;

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [C_DATA_WIDTH-1:0] cdf_q, cdf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    hist_wren_q, hist_wren_d;
  logic [C_ADDR_WIDTH-1:0] hist_addr_q, hist_addr_d;
  logic                    lut_wren_q, lut_wren_d;
  logic [C_ADDR_WIDTH-1:0] lut_addr_q, lut_addr_d;
  logic [C_OUT_WIDTH-1:0]  lut_din_q, lut_din_d;

  logic [C_DATA_WIDTH-1:0] cdf_sum;
  logic [PW-1:0]           prod;
  logic [PW-1:0]           scaled;
  logic [C_OUT_WIDTH-1:0]  lut_map;
  logic                    is_last;

  assign cdf_sum = cdf_q + bus.hist_dout;
  assign prod    = PW'(cdf_sum) * K;
  assign scaled  = prod >> 24;
  assign lut_map = (scaled > PW'(M)) ? C_OUT_WIDTH'(M) : scaled[C_OUT_WIDTH-1:0];
  assign is_last = &idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cdf_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hist_wren_q <= 1'b0;
      hist_addr_q <= '0;
      lut_wren_q  <= 1'b0;
      lut_addr_q  <= '0;
      lut_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cdf_q       <= cdf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hist_wren_q <= hist_wren_d;
      hist_addr_q <= hist_addr_d;
      lut_wren_q  <= lut_wren_d;
      lut_addr_q  <= lut_addr_d;
      lut_din_q   <= lut_din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cdf_d   = cdf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRead;
          idx_d   = '0;
          cdf_d   = '0;
        end
      end
      StRead:  state_d = StClear;
      StClear: begin
        cdf_d = cdf_sum;
        if (is_last) begin
          state_d = StDone;
        end else begin
          state_d = StRead;
          idx_d   = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    hist_wren_d = (state_d == StClear);
    hist_addr_d = ((state_d == StRead) || (state_d == StClear)) ? idx_d : '0;
    lut_wren_d  = (state_q == StClear);
    lut_addr_d  = (state_q == StClear) ? idx_q : lut_addr_q;
    lut_din_d   = (state_q == StClear) ? lut_map : lut_din_q;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hist_wren = hist_wren_q;
  assign bus.hist_addr = hist_addr_q;
  assign bus.hist_din  = '0;
  assign bus.lut_wren  = lut_wren_q;
  assign bus.lut_addr  = lut_addr_q;
  assign bus.lut_din   = lut_din_q;

endmodule

// File: tb/tb_hist_cdf_lut_gen.sv
// Directed bench for hist_cdf_lut_gen with histogram/LUT RAM models and an expected-LUT queue.
module tb_hist_cdf_lut_gen;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 20;
  localparam int unsigned OW  = 8;
  localparam int unsigned PIX = 1024;
  localparam int unsigned NB  = 2 ** AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [OW-1:0] din;
  } lut_exp_t;

  logic clk;
  logic rst_n;
  logic ld_all;

  logic [DW-1:0] mem      [NB];
  logic [DW-1:0] init_mem [NB];
  logic [OW-1:0] lut_mem  [NB];

  lut_exp_t exp_q [$];

  int checks;
  int errors;
  int first_lut, done_cyc, busy_off, done_cnt, lut_cnt, hw_cnt, din_bad;
  logic b1, b513;

  hist_cdf_lut_gen_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_OUT_WIDTH(OW)) bus ();

  hist_cdf_lut_gen #(
    .C_ADDR_WIDTH(AW),
    .C_DATA_WIDTH(DW),
    .C_PIX_NUM   (PIX),
    .C_OUT_WIDTH (OW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Histogram RAM: registered read, read data held during a write.
  always @(posedge clk) begin
    if (ld_all) begin
      mem <= init_mem;
    end else if (bus.hist_wren) begin
      mem[bus.hist_addr] <= bus.hist_din;
    end else begin
      bus.hist_dout <= mem[bus.hist_addr];
    end
  end

  always @(posedge clk) begin
    if (bus.lut_wren) lut_mem[bus.lut_addr] <= bus.lut_din;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] map_ref(input longint unsigned c);
    longint unsigned m = (64'd1 << OW) - 1;
    longint unsigned k = ((m << 24) + PIX - 1) / PIX;
    longint unsigned v = (c * k) >> 24;
    return (v > m) ? OW'(m) : OW'(v);
  endfunction

  task automatic load_hist();
    ld_all = 1'b1;
    @(posedge clk);
    #1 ld_all = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_model();
    longint unsigned c = 0;
    lut_exp_t e;
    for (int i = 0; i < NB; i++) begin
      c = (c + longint'(mem[i])) & ((64'd1 << DW) - 1);
      e.addr = AW'(i);
      e.din  = map_ref(c);
      exp_q.push_back(e);
    end
  endtask

  // Called at a falling edge; cycle n is the n-th cycle after the edge that samples start.
  task automatic run_sweep(input int inj_a, input int inj_b, input int rst_at);
    lut_exp_t e;
    first_lut = -1; done_cyc = -1; busy_off = -1;
    done_cnt = 0; lut_cnt = 0; hw_cnt = 0; din_bad = 0; b1 = 1'b0; b513 = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 530; n++) begin
      @(negedge clk);
      bus.start = (n == inj_a) || (n == inj_b);
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({bus.busy, bus.done, bus.hist_wren, bus.hist_addr, bus.hist_din,
                   bus.lut_wren, bus.lut_addr, bus.lut_din}), 64'd0);
        exp_q.delete();
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (n == 1) b1 = bus.busy;
      if (n == 513) b513 = bus.busy;
      if (bus.hist_wren) begin
        hw_cnt++;
        if (bus.hist_din !== '0) din_bad++;
      end
      if (bus.lut_wren) begin
        lut_cnt++;
        if (first_lut < 0) first_lut = n;
        if (exp_q.size() == 0) begin
          check("lut_unexpected_write", 64'(bus.lut_addr), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("lut_addr", 64'(bus.lut_addr), 64'(e.addr));
          check("lut_din", 64'(bus.lut_din), 64'(e.din));
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (!bus.busy) begin
        busy_off = n;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic sweep_checks();
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("lut_write_count", 64'(lut_cnt), 64'(NB));
    check("hist_write_count", 64'(hw_cnt), 64'(NB));
    check("hist_din_nonzero", 64'(din_bad), 64'd0);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_off_cycle", 64'(busy_off), 64'd514);
  endtask

  function automatic int hist_nonzero();
    int cnt = 0;
    for (int i = 0; i < NB; i++) if (mem[i] != '0) cnt++;
    return cnt;
  endfunction

  initial begin
    int cnt;
    logic mono;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ld_all = 1'b0;
    bus.start = 1'b0;
    bus.hist_dout = '0;
    for (int i = 0; i < NB; i++) begin
      init_mem[i] = '0;
      lut_mem[i]  = '0;
    end
    #1;
    check("reset_outputs",
          64'({bus.busy, bus.done, bus.hist_wren, bus.hist_addr, bus.hist_din,
               bus.lut_wren, bus.lut_addr, bus.lut_din}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform histogram: lut[i] = floor((i+1)*255/256).
    for (int i = 0; i < NB; i++) init_mem[i] = DW'(4);
    load_hist();
    push_model();
    run_sweep(0, 0, 0);
    sweep_checks();
    check("uniform_lut0", 64'(lut_mem[0]), 64'd0);
    check("uniform_lut127", 64'(lut_mem[127]), 64'd127);
    check("uniform_lut255", 64'(lut_mem[255]), 64'd255);
    check("uniform_hist_cleared", 64'(hist_nonzero()), 64'd0);

    // Single full bin at 100.
    for (int i = 0; i < NB; i++) init_mem[i] = '0;
    init_mem[100] = DW'(1024);
    load_hist();
    push_model();
    run_sweep(0, 0, 0);
    sweep_checks();
    check("spike_lut99", 64'(lut_mem[99]), 64'd0);
    check("spike_lut100", 64'(lut_mem[100]), 64'd255);
    check("spike_hist_cleared", 64'(hist_nonzero()), 64'd0);

    // All pixels in the last bin, plus sweep timing.
    for (int i = 0; i < NB; i++) init_mem[i] = '0;
    init_mem[255] = DW'(307200);
    load_hist();
    push_model();
    run_sweep(0, 0, 0);
    sweep_checks();
    check("first_lut_cycle", 64'(first_lut), 64'd3);
    check("done_cycle", 64'(done_cyc), 64'd513);
    check("busy_cycle1", 64'(b1), 64'd1);
    check("busy_cycle513", 64'(b513), 64'd1);
    check("last_lut254", 64'(lut_mem[254]), 64'd0);
    check("last_lut255", 64'(lut_mem[255]), 64'd255);

    // Starts while busy and in the done cycle are ignored; start right after done restarts.
    for (int i = 0; i < NB; i++) init_mem[i] = DW'(2);
    load_hist();
    push_model();
    run_sweep(50, 513, 0);
    sweep_checks();
    push_model();
    run_sweep(0, 0, 0);
    sweep_checks();
    cnt = 0;
    for (int i = 0; i < NB; i++) if (lut_mem[i] != '0) cnt++;
    check("restart_lut_all_zero", 64'(cnt), 64'd0);

    // Reset mid-sweep, then a full sweep over the partially cleared histogram.
    for (int i = 0; i < NB; i++) init_mem[i] = DW'(3);
    load_hist();
    push_model();
    run_sweep(0, 0, 200);
    cnt = 0;
    for (int i = 100; i < NB; i++) if (mem[i] == DW'(3)) cnt++;
    check("reset_upper_bins_kept", 64'(cnt), 64'd156);
    cnt = 0;
    for (int i = 0; i < 99; i++) if (mem[i] != '0) cnt++;
    check("reset_lower_bins_cleared", 64'(cnt), 64'd0);
    push_model();
    run_sweep(0, 0, 0);
    sweep_checks();
    check("post_reset_hist_cleared", 64'(hist_nonzero()), 64'd0);

    // Random histogram summing to the pixel count.
    for (int i = 0; i < NB; i++) init_mem[i] = '0;
    for (int p = 0; p < int'(PIX); p++) begin
      cnt = int'($urandom_range(NB - 1));
      init_mem[cnt] = init_mem[cnt] + 1'b1;
    end
    load_hist();
    push_model();
    run_sweep(0, 0, 0);
    sweep_checks();
    mono = 1'b1;
    for (int i = 1; i < NB; i++) if (lut_mem[i] < lut_mem[i-1]) mono = 1'b0;
    check("random_lut_monotonic", 64'(mono), 64'd1);
    check("random_lut255", 64'(lut_mem[255]), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
